socaudio_nios_jtag_host: RTL and testbench
==========================================

SOCAUDIO_NIOS_JTAG_HOST -- requirements
Module: socaudio_nios_jtag_host

Interface
REQ-001 SHALL have parameter DR_WIDTH, default 38: debug data-register scan length in bits.
REQ-002 SHALL have parameter TCK_DIV, default 2, legal 1..255: clk cycles per TCK half-period.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port cmd_valid, input, 1: scan command request.
REQ-006 SHALL have port cmd_ready, output, 1: ready to accept a command.
REQ-007 SHALL have port cmd_ir, input, 2: virtual IR value for the scan.
REQ-008 SHALL have port cmd_dr, input, DR_WIDTH: data shifted out, LSB first.
REQ-009 SHALL have port rsp_valid, output, 1: scan result available.
REQ-010 SHALL have port rsp_ready, input, 1: result accepted.
REQ-011 SHALL have port rsp_dr, output, DR_WIDTH: captured TDO bits; the first captured bit is at the LSB.
REQ-012 SHALL have port rsp_ir_out, output, 2: vji_ir_out sampled during the scan.
REQ-013 SHALL have port vji_tck, output, 1: generated TCK.
REQ-014 SHALL have port vji_tdi, output, 1: serial data to the slave.
REQ-015 SHALL have port vji_tdo, input, 1: serial data from the slave.
REQ-016 SHALL have port vji_ir_in, output, 2: IR presented to the slave.
REQ-017 SHALL have port vji_ir_out, input, 2: IR status returned by the slave.
REQ-018 SHALL have ports vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, output, 1 each: virtual-state strobes.

Function
REQ-019 SHALL run states IDLE, UIR, CDR, SDR, UDR, RTI, RESP.
REQ-020 SHALL make each TCK period 2*TCK_DIV clk cycles: vji_tck low for the first half, high for the second. State advances only at the end of a period.
REQ-021 SHALL assert cmd_ready only in IDLE; on cmd_valid&&cmd_ready, SHALL latch cmd_ir/cmd_dr, load vji_ir_in=cmd_ir and enter UIR on the same edge.
REQ-022 SHALL hold UIR, CDR, UDR and RTI for 1 TCK period each, and SDR for exactly DR_WIDTH periods.
REQ-023 SHALL assert exactly the one strobe matching the current state, and none in IDLE or RESP.
REQ-024 SHALL drive vji_tdi from shift[0] in SDR, stable across the whole period, and 0 otherwise.
REQ-025 SHALL sample vji_tdo on the last clk cycle of the low phase, then shift right with the sample entering the MSB.
REQ-026 SHALL capture vji_ir_out into rsp_ir_out on UDR entry.
REQ-027 SHALL raise rsp_valid exactly (DR_WIDTH+4)*2*TCK_DIV clk cycles after the accept edge.
REQ-028 SHALL hold rsp_valid, rsp_dr and rsp_ir_out stable in RESP until rsp_ready, then return to IDLE on the next edge.
REQ-029 SHALL hold vji_tck low in IDLE and RESP; vji_ir_in SHALL keep its last value.
REQ-030 SHALL ignore cmd_valid outside IDLE, and SHALL NOT abort a scan in progress.

Reset
REQ-031 SHALL, while reset_n=0, immediately force: state IDLE, cmd_ready=1, rsp_valid=0, rsp_dr=0, rsp_ir_out=0, vji_tck=0, vji_tdi=0, vji_ir_in=0, all strobes 0, divider counter 0.
REQ-032 SHALL discard any scan in progress at reset assertion; no partial result SHALL be presented.

Structure
REQ-033 SHALL put the state enum, IR width constant (2) and DR_WIDTH default in shared package socaudio_nios_jtag_host_pkg.
REQ-034 SHALL implement the TCK divider as sub-module socaudio_nios_jtag_host_tckgen, outputting tck level, sample tick (end of low phase) and period-end tick.

Verification
REQ-035 SHALL test loopback: tdo driven from tdi, cmd_ir=2'b01, cmd_dr=38'h15_A5A5_A5A5 -> rsp_dr=38'h15_A5A5_A5A5, vji_ir_in=2'b01.
REQ-036 SHALL test timing with TCK_DIV=2: rsp_valid rises exactly 168 cycles after accept; vji_sdr is high for 152 consecutive cycles; each strobe is high for 4 cycles.
REQ-037 SHALL test tdo tied 1 with vji_ir_out=2'b10 -> rsp_dr=38'h3F_FFFF_FFFF, rsp_ir_out=2'b10.
REQ-038 SHALL test backpressure: rsp_ready held low 10 cycles -> rsp_valid, rsp_dr stable and cmd_ready=0; a cmd_valid pulse during that time is not accepted.
REQ-039 SHALL test reset after 20 SDR bits -> all outputs at REQ-031 values in the same cycle; cmd_ready=1 after release; the next scan completes correctly.
REQ-040 SHALL test TCK_DIV=1 back-to-back: second command accepted 1 cycle after the first rsp handshake; rsp_valid again 84 cycles after the second accept.

Source files
------------

// File: rtl/socaudio_nios_jtag_host_pkg.sv
// Shared definitions for the Nios JTAG host: scan FSM states and interface widths.
package socaudio_nios_jtag_host_pkg;

  // Virtual IR width of the vJTAG slave.
  localparam int IR_W = 2;

  // Default debug data-register scan length.
  localparam int DR_WIDTH_DEFAULT = 38;

  // Scan sequencer states, in the order a scan walks through them.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UIR  = 3'd1,
    ST_CDR  = 3'd2,
    ST_SDR  = 3'd3,
    ST_UDR  = 3'd4,
    ST_RTI  = 3'd5,
    ST_RESP = 3'd6
  } state_t;

  // True while a scan is driving TCK (every state between accept and response).
  function automatic logic scan_active(input state_t st);
    return (st == ST_UIR) || (st == ST_CDR) || (st == ST_SDR) ||
           (st == ST_UDR) || (st == ST_RTI);
  endfunction

endpackage

// File: rtl/socaudio_nios_jtag_host_tckgen.sv
// TCK divider: one TCK period is 2*TCK_DIV clk cycles, low half first.
// Produces the TCK level, a tick on the last low-phase cycle (TDO sample
// point) and a tick on the last cycle of the period (state advance point).
module socaudio_nios_jtag_host_tckgen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tck,
  output logic sample_tick,
  output logic period_end
);

  localparam int CW = 9;
  localparam logic [CW-1:0] HALF = CW'(TCK_DIV);
  localparam logic [CW-1:0] SAMP = CW'(TCK_DIV - 1);
  localparam logic [CW-1:0] LAST = CW'(2 * TCK_DIV - 1);

  logic [CW-1:0] cnt;

  // Period counter; parked at zero whenever no scan is running so every scan
  // starts with a fresh low phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tck         = run && (cnt >= HALF);
  assign sample_tick = run && (cnt == SAMP);
  assign period_end  = run && (cnt == LAST);

endmodule

// File: rtl/socaudio_nios_jtag_host.sv
// Nios JTAG host: turns a command (virtual IR + DR word) into one vJTAG scan
// sequence UIR -> CDR -> SDR x DR_WIDTH -> UDR -> RTI and returns the
// captured TDO bits plus the slave's IR status.
module socaudio_nios_jtag_host
  import socaudio_nios_jtag_host_pkg::*;
#(
  parameter int DR_WIDTH = DR_WIDTH_DEFAULT,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_W-1:0]     cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_W-1:0]     rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_W-1:0]     vji_ir_in,
  input  logic [IR_W-1:0]     vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int BCW = $clog2(DR_WIDTH + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DR_WIDTH - 1);

  state_t              state;
  state_t              state_nxt;
  logic                run;
  logic                tck_lvl;
  logic                sample_tick;
  logic                period_end;
  logic                accept;
  logic [BCW-1:0]      bit_cnt;
  logic [DR_WIDTH-1:0] shift;
  logic                tdo_bit;

  assign run    = scan_active(state);
  assign accept = (state == ST_IDLE) && cmd_valid;

  socaudio_nios_jtag_host_tckgen #(
    .TCK_DIV (TCK_DIV)
  ) u_tckgen (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .tck         (tck_lvl),
    .sample_tick (sample_tick),
    .period_end  (period_end)
  );

  // Next-state logic: every scan state except SDR lasts one TCK period; SDR
  // lasts until the last DR bit's period ends. RESP waits for the consumer.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cmd_valid) state_nxt = ST_UIR;
      ST_UIR:  if (period_end) state_nxt = ST_CDR;
      ST_CDR:  if (period_end) state_nxt = ST_SDR;
      ST_SDR:  if (period_end && (bit_cnt == BIT_LAST)) state_nxt = ST_UDR;
      ST_UDR:  if (period_end) state_nxt = ST_RTI;
      ST_RTI:  if (period_end) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset drops any scan in flight back to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counts completed SDR periods so the shift phase ends after DR_WIDTH bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
    end else if (accept) begin
      bit_cnt <= '0;
    end else if ((state == ST_SDR) && period_end) begin
      bit_cnt <= bit_cnt + BCW'(1);
    end
  end

  // IR presented to the slave: loaded on accept, held between scans.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vji_ir_in <= '0;
    end else if (accept) begin
      vji_ir_in <= cmd_ir;
    end
  end

  // Shift register and TDO sample. TDO is sampled at the end of the low phase
  // but only shifted in at period end, so TDI (shift[0]) stays stable for the
  // whole TCK period. Pure datapath: reloaded on every accept, never exposed.
  always_ff @(posedge clk) begin
    if (accept) begin
      shift <= cmd_dr;
    end else if ((state == ST_SDR) && period_end) begin
      shift <= {tdo_bit, shift[DR_WIDTH-1:1]};
    end
    if ((state == ST_SDR) && sample_tick) begin
      tdo_bit <= vji_tdo;
    end
  end

  // Slave IR status is captured as the scan enters UDR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_ir_out <= '0;
    end else if ((state == ST_SDR) && (state_nxt == ST_UDR)) begin
      rsp_ir_out <= vji_ir_out;
    end
  end

  // Result word is only written once the full scan has finished, so a reset
  // mid-scan can never leave a partial result visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_dr <= '0;
    end else if ((state == ST_RTI) && period_end) begin
      rsp_dr <= shift;
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign vji_tck   = tck_lvl;
  assign vji_tdi   = (state == ST_SDR) && shift[0];
  assign vji_uir   = (state == ST_UIR);
  assign vji_cdr   = (state == ST_CDR);
  assign vji_sdr   = (state == ST_SDR);
  assign vji_udr   = (state == ST_UDR);
  assign vji_rti   = (state == ST_RTI);

endmodule

// File: tb/tb_socaudio_nios_jtag_host.sv
// Directed bench for socaudio_nios_jtag_host: one instance at TCK_DIV=2 and
// one at TCK_DIV=1, both with DR_WIDTH=38.
module tb_socaudio_nios_jtag_host;

  localparam int DRW = 38;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  always #5 clk = ~clk;

  // Instance A: TCK_DIV = 2
  logic           a_cmd_valid = 1'b0;
  logic           a_cmd_ready;
  logic [1:0]     a_cmd_ir = 2'b00;
  logic [DRW-1:0] a_cmd_dr = '0;
  logic           a_rsp_valid;
  logic           a_rsp_ready = 1'b0;
  logic [DRW-1:0] a_rsp_dr;
  logic [1:0]     a_rsp_ir_out;
  logic           a_tck, a_tdi, a_tdo;
  logic [1:0]     a_ir_in;
  logic [1:0]     a_ir_out = 2'b11;
  logic           a_uir, a_cdr, a_sdr, a_udr, a_rti;
  logic           a_tie1 = 1'b0;

  assign a_tdo = a_tie1 ? 1'b1 : a_tdi;

  socaudio_nios_jtag_host #(.DR_WIDTH(DRW), .TCK_DIV(2)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_ir(a_cmd_ir), .cmd_dr(a_cmd_dr),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_dr(a_rsp_dr), .rsp_ir_out(a_rsp_ir_out),
    .vji_tck(a_tck), .vji_tdi(a_tdi), .vji_tdo(a_tdo),
    .vji_ir_in(a_ir_in), .vji_ir_out(a_ir_out),
    .vji_uir(a_uir), .vji_cdr(a_cdr), .vji_sdr(a_sdr),
    .vji_udr(a_udr), .vji_rti(a_rti)
  );

  // Instance B: TCK_DIV = 1, TDO looped back from TDI
  logic           b_cmd_valid = 1'b0;
  logic           b_cmd_ready;
  logic [1:0]     b_cmd_ir = 2'b00;
  logic [DRW-1:0] b_cmd_dr = '0;
  logic           b_rsp_valid;
  logic           b_rsp_ready = 1'b0;
  logic [DRW-1:0] b_rsp_dr;
  logic [1:0]     b_rsp_ir_out;
  logic           b_tck, b_tdi, b_tdo;
  logic [1:0]     b_ir_in;
  logic [1:0]     b_ir_out = 2'b01;
  logic           b_uir, b_cdr, b_sdr, b_udr, b_rti;

  assign b_tdo = b_tdi;

  socaudio_nios_jtag_host #(.DR_WIDTH(DRW), .TCK_DIV(1)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_ir(b_cmd_ir), .cmd_dr(b_cmd_dr),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_dr(b_rsp_dr), .rsp_ir_out(b_rsp_ir_out),
    .vji_tck(b_tck), .vji_tdi(b_tdi), .vji_tdo(b_tdo),
    .vji_ir_in(b_ir_in), .vji_ir_out(b_ir_out),
    .vji_uir(b_uir), .vji_cdr(b_cdr), .vji_sdr(b_sdr),
    .vji_udr(b_udr), .vji_rti(b_rti)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_uir, cnt_cdr, cnt_sdr, cnt_udr, cnt_rti, max_sdr_run, sdr_run;
  int lat;
  logic [DRW-1:0] held_dr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_sample();
    if (a_uir) cnt_uir++;
    if (a_cdr) cnt_cdr++;
    if (a_udr) cnt_udr++;
    if (a_rti) cnt_rti++;
    if (a_sdr) begin
      cnt_sdr++;
      sdr_run++;
      if (sdr_run > max_sdr_run) max_sdr_run = sdr_run;
    end else begin
      sdr_run = 0;
    end
  endtask

  // Accept a command on A, then count edges until rsp_valid (bounded).
  task automatic a_scan(input logic [1:0] ir, input logic [DRW-1:0] dr, output int n);
    a_cmd_ir = ir;
    a_cmd_dr = dr;
    a_cmd_valid = 1'b1;
    tick();
    a_cmd_valid = 1'b0;
    cnt_uir = 0; cnt_cdr = 0; cnt_sdr = 0; cnt_udr = 0; cnt_rti = 0;
    max_sdr_run = 0; sdr_run = 0;
    n = 0;
    a_sample();
    while (!a_rsp_valid && n < 1000) begin
      tick();
      n++;
      a_sample();
    end
  endtask

  task automatic b_wait(output int n);
    n = 0;
    while (!b_rsp_valid && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic a_handshake();
    a_rsp_ready = 1'b1;
    tick();
    a_rsp_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    #1 reset_n = 1'b0;
    #1;
    check("rst_cmd_ready", a_cmd_ready, 1'b1);
    check("rst_rsp_valid", a_rsp_valid, 1'b0);
    check("rst_tck", a_tck, 1'b0);
    check("rst_tdi", a_tdi, 1'b0);
    check("rst_ir_in", a_ir_in, 2'b00);
    check("rst_strobes", {a_uir, a_cdr, a_sdr, a_udr, a_rti}, 5'b0);
    check("rst_rsp_dr", a_rsp_dr, '0);
    check("rst_rsp_ir_out", a_rsp_ir_out, 2'b00);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    check("post_rst_cmd_ready", a_cmd_ready, 1'b1);

    // Loopback scan, timing and strobe widths at TCK_DIV=2
    a_ir_out = 2'b11;
    a_scan(2'b01, 38'h15_A5A5_A5A5, lat);
    check("lb_latency", lat, 168);
    check("lb_sdr_cycles", cnt_sdr, 152);
    check("lb_sdr_consecutive", max_sdr_run, 152);
    check("lb_uir_cycles", cnt_uir, 4);
    check("lb_cdr_cycles", cnt_cdr, 4);
    check("lb_udr_cycles", cnt_udr, 4);
    check("lb_rti_cycles", cnt_rti, 4);
    check("lb_rsp_dr", a_rsp_dr, 38'h15_A5A5_A5A5);
    check("lb_ir_in", a_ir_in, 2'b01);
    check("lb_rsp_ir_out", a_rsp_ir_out, 2'b11);
    check("lb_tck_resp", a_tck, 1'b0);
    a_handshake();
    check("lb_idle_ready", a_cmd_ready, 1'b1);
    check("lb_idle_valid", a_rsp_valid, 1'b0);

    // TDO tied high, slave IR status 2'b10
    a_tie1 = 1'b1;
    a_ir_out = 2'b10;
    a_scan(2'b11, 38'h00_0000_0000, lat);
    a_tie1 = 1'b0;
    check("t1_latency", lat, 168);
    check("t1_rsp_dr", a_rsp_dr, 38'h3F_FFFF_FFFF);
    check("t1_rsp_ir_out", a_rsp_ir_out, 2'b10);

    // Backpressure: rsp_ready low 10 cycles, a cmd_valid pulse must be ignored
    held_dr = a_rsp_dr;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        a_cmd_ir = 2'b00;
        a_cmd_valid = 1'b1;
      end else begin
        a_cmd_valid = 1'b0;
      end
      tick();
      check("bp_rsp_valid", a_rsp_valid, 1'b1);
      check("bp_rsp_dr", a_rsp_dr, held_dr);
      check("bp_cmd_ready", a_cmd_ready, 1'b0);
    end
    a_cmd_valid = 1'b0;
    check("bp_ir_in_kept", a_ir_in, 2'b11);
    a_handshake();
    check("bp_release_valid", a_rsp_valid, 1'b0);
    check("bp_release_ready", a_cmd_ready, 1'b1);
    tick();
    check("bp_no_accept", a_cmd_ready, 1'b1);

    // Reset after 20 SDR bits
    a_cmd_ir = 2'b10;
    a_cmd_dr = 38'h3F_0F0F_0F0F;
    a_cmd_valid = 1'b1;
    tick();
    a_cmd_valid = 1'b0;
    repeat (88) tick();
    check("mid_in_sdr", a_sdr, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_cmd_ready", a_cmd_ready, 1'b1);
    check("mid_rst_rsp_valid", a_rsp_valid, 1'b0);
    check("mid_rst_rsp_dr", a_rsp_dr, '0);
    check("mid_rst_rsp_ir_out", a_rsp_ir_out, 2'b00);
    check("mid_rst_tck", a_tck, 1'b0);
    check("mid_rst_tdi", a_tdi, 1'b0);
    check("mid_rst_ir_in", a_ir_in, 2'b00);
    check("mid_rst_strobes", {a_uir, a_cdr, a_sdr, a_udr, a_rti}, 5'b0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    check("mid_rel_cmd_ready", a_cmd_ready, 1'b1);
    check("mid_rel_rsp_valid", a_rsp_valid, 1'b0);
    a_ir_out = 2'b01;
    a_scan(2'b10, 38'h2A_1234_5678, lat);
    check("re_latency", lat, 168);
    check("re_rsp_dr", a_rsp_dr, 38'h2A_1234_5678);
    check("re_rsp_ir_out", a_rsp_ir_out, 2'b01);
    check("re_ir_in", a_ir_in, 2'b10);
    a_handshake();

    // Back-to-back at TCK_DIV=1
    b_cmd_ir = 2'b01;
    b_cmd_dr = 38'h00_DEAD_BEEF;
    b_cmd_valid = 1'b1;
    tick();
    b_cmd_valid = 1'b0;
    check("b1_strobes", {b_uir, b_cdr, b_sdr, b_udr, b_rti}, 5'b10000);
    b_wait(lat);
    check("b1_latency", lat, 84);
    check("b1_rsp_dr", b_rsp_dr, 38'h00_DEAD_BEEF);
    check("b1_rsp_ir_out", b_rsp_ir_out, 2'b01);
    check("b1_tck_resp", b_tck, 1'b0);
    b_rsp_ready = 1'b1;
    b_cmd_ir = 2'b10;
    b_cmd_dr = 38'h31_5A5A_C3C3;
    b_cmd_valid = 1'b1;
    tick();
    b_rsp_ready = 1'b0;
    check("b_hs_idle_ready", b_cmd_ready, 1'b1);
    check("b_hs_idle_valid", b_rsp_valid, 1'b0);
    tick();
    b_cmd_valid = 1'b0;
    check("b2_accepted", b_cmd_ready, 1'b0);
    check("b2_ir_in", b_ir_in, 2'b10);
    b_ir_out = 2'b11;
    b_wait(lat);
    check("b2_latency", lat, 84);
    check("b2_rsp_dr", b_rsp_dr, 38'h31_5A5A_C3C3);
    check("b2_rsp_ir_out", b_rsp_ir_out, 2'b11);
    b_rsp_ready = 1'b1;
    tick();
    b_rsp_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
